fadd_issue: RTL and testbench

//  Initiator side of the FPU adder's ready/valid port. Accepts add-class ops from the core pipeline.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fadd_issue.sv | 134 +++++++++++++
 tb/tb_fadd_issue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU encodings, issue FSM states and IEEE754 constants
package fpu_pkg;

   // Add-class op encoding as presented on req_op
   typedef enum logic [1:0] {
      FOP_FADD = 2'b00,
      FOP_FSUB = 2'b01,
      FOP_FNEG = 2'b10,
      FOP_FABS = 2'b11
   } fop_e;

   // Issue FSM: IDLE takes ops, BUSY waits on the adder, HOLD presents the response
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      HOLD = 2'b10
   } fadd_state_e;

   localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;

endpackage

// File: rtl/fadd_issue.sv
// rtl/fadd_issue.sv - ready/valid initiator for the FPU adder with sign-op bypass and timeout
module fadd_issue
   import fpu_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_x1,
   input  logic [31:0]      req_x2,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_y,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic [31:0]      fadd_x1,
   output logic [31:0]      fadd_x2,
   output logic             fadd_ready,
   input  logic             fadd_valid,
   input  logic [31:0]      fadd_y
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fadd_state_e      state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [31:0]      fadd_x1_q, fadd_x1_d;
   logic [31:0]      fadd_x2_q, fadd_x2_d;
   logic [31:0]      rsp_y_q,   rsp_y_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_err_q, rsp_err_d;
   fop_e             op;

   assign op = fop_e'(req_op);

   // Handshake outputs decode straight from the state flop; rst only masks req_ready
   assign req_ready  = (state_q == IDLE) && !rst;
   assign fadd_ready = (state_q == BUSY);
   assign rsp_valid  = (state_q == HOLD);
   assign fadd_x1    = fadd_x1_q;
   assign fadd_x2    = fadd_x2_q;
   assign rsp_y      = rsp_y_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_err    = rsp_err_q;

   // Next-state: accept/route ops, wait on adder or timeout, hold response until taken
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fadd_x1_d = fadd_x1_q;
      fadd_x2_d = fadd_x2_q;
      rsp_y_d   = rsp_y_q;
      rsp_tag_d = rsp_tag_q;
      rsp_err_d = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               rsp_tag_d = req_tag;
               rsp_err_d = 1'b0;
               unique case (op)
                  FOP_FADD: begin
                     fadd_x1_d = req_x1;
                     fadd_x2_d = req_x2;
                     cnt_d     = '0;
                     state_d   = BUSY;
                  end
                  FOP_FSUB: begin
                     fadd_x1_d = req_x1;
                     fadd_x2_d = req_x2 ^ SIGN_MASK;
                     cnt_d     = '0;
                     state_d   = BUSY;
                  end
                  FOP_FNEG: begin
                     rsp_y_d = req_x1 ^ SIGN_MASK;
                     state_d = HOLD;
                  end
                  FOP_FABS: begin
                     rsp_y_d = req_x1 & ~SIGN_MASK;
                     state_d = HOLD;
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A valid in the expiry cycle still counts as a good result
            if (fadd_valid) begin
               rsp_y_d   = fadd_y;
               rsp_err_d = 1'b0;
               state_d   = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               rsp_y_d   = QNAN;
               rsp_err_d = 1'b1;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fadd_x1_q <= '0;
         fadd_x2_q <= '0;
         rsp_y_q   <= '0;
         rsp_tag_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fadd_x1_q <= fadd_x1_d;
         fadd_x2_q <= fadd_x2_d;
         rsp_y_q   <= rsp_y_d;
         rsp_tag_q <= rsp_tag_d;
         rsp_err_q <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_fadd_issue.sv
// tb/tb_fadd_issue.sv - directed scoreboard bench for fadd_issue
module tb_fadd_issue;

   localparam int TAG_W = 5;

   typedef struct {
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic [31:0]      req_x1 = '0;
   logic [31:0]      req_x2 = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [31:0]      rsp_y;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;
   logic [31:0]      fadd_x1;
   logic [31:0]      fadd_x2;
   logic             fadd_ready;
   logic             fadd_valid;
   logic [31:0]      fadd_y;

   logic             stub_en = 1'b1;
   logic             force_valid = 1'b0;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail = 0;

   fadd_issue #(.TAG_W(TAG_W), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_y      (rsp_y),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .fadd_x1    (fadd_x1),
      .fadd_x2    (fadd_x2),
      .fadd_ready (fadd_ready),
      .fadd_valid (fadd_valid),
      .fadd_y     (fadd_y)
   );

   always #5 clk = ~clk;

   // Combinational adder stub: knows only the operand pairs this bench uses
   assign fadd_valid = (fadd_ready & stub_en) | force_valid;
   always_comb begin
      fadd_y = 32'hDEAD_BEEF;
      if (fadd_x1 == 32'h3F80_0000 && fadd_x2 == 32'h4000_0000) fadd_y = 32'h4040_0000;
      if (fadd_x1 == 32'h4040_0000 && fadd_x2 == 32'hBF80_0000) fadd_y = 32'h4000_0000;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge, follow it to its response, then hand it back
   task automatic do_op(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [TAG_W-1:0] tag, input logic [31:0] exp_y, input logic exp_err,
                        input int exp_lat, input int exp_busy, input logic [31:0] exp_x2,
                        input int hold, input logic pulse);
      int   lat;
      int   busy;
      exp_t e;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_x1    = x1;
      req_x2    = x2;
      req_tag   = tag;
      @(posedge clk);
      exp_q.push_back('{y: exp_y, tag: tag, err: exp_err});
      @(negedge clk);
      req_valid = 1'b0;
      req_x1    = $urandom;
      req_x2    = $urandom;
      req_tag   = TAG_W'($urandom);
      lat  = 1;
      busy = 0;
      while (!rsp_valid && lat < 100) begin
         if (fadd_ready) begin
            if (busy == 0) check("fadd_x2_busy", fadd_x2, exp_x2);
            busy++;
         end
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(busy), 32'(exp_busy));
      check("req_ready_hold", 32'(req_ready), 32'd0);
      check("fadd_ready_hold", 32'(fadd_ready), 32'd0);
      e = exp_q[0];
      for (int h = 0; h < hold; h++) begin
         check("rsp_y_stable", rsp_y, e.y);
         check("rsp_tag_stable", 32'(rsp_tag), 32'(e.tag));
         check("req_ready_stall", 32'(req_ready), 32'd0);
         force_valid = pulse;
         @(posedge clk);
         @(negedge clk);
         force_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      e = exp_q.pop_front();
      check("rsp_y", rsp_y, e.y);
      check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      check("req_ready_back", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_fadd_ready", 32'(fadd_ready), 32'd0);
      check("rst_fadd_x1", fadd_x1, 32'd0);
      check("rst_fadd_x2", fadd_x2, 32'd0);
      check("rst_rsp_y", rsp_y, 32'd0);
      check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_release_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      // 1) fadd 1.0 + 2.0
      do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 1'b0, 2, 1, 32'h4000_0000, 0, 1'b0);
      // 2) fsub 3.0 - 1.0, adder must see -1.0
      do_op(2'b01, 32'h4040_0000, 32'h3F80_0000, 5'd6, 32'h4000_0000, 1'b0, 2, 1, 32'hBF80_0000, 0, 1'b0);
      // 3) bypass ops never touch the adder
      do_op(2'b10, 32'h3F80_0000, 32'h1234_5678, 5'd1, 32'hBF80_0000, 1'b0, 1, 0, 32'h0, 0, 1'b0);
      do_op(2'b11, 32'hC000_0000, 32'h4000_0000, 5'd2, 32'h4000_0000, 1'b0, 1, 0, 32'h0, 0, 1'b0);
      do_op(2'b10, 32'h7FC0_0001, 32'h0, 5'd31, 32'hFFC0_0001, 1'b0, 1, 0, 32'h0, 0, 1'b0);
      // 4) response held for 5 cycles
      do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 1'b0, 2, 1, 32'h4000_0000, 5, 1'b0);
      // 5) adder never answers: timeout after 16 BUSY cycles, late valid ignored
      stub_en = 1'b0;
      do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd7, 32'h7FC0_0000, 1'b1, 17, 16, 32'h4000_0000, 3, 1'b1);
      stub_en = 1'b1;
      do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd8, 32'h4040_0000, 1'b0, 2, 1, 32'h4000_0000, 0, 1'b0);

      // 6) reset during BUSY drops the op
      stub_en   = 1'b0;
      req_valid = 1'b1;
      req_op    = 2'b00;
      req_x1    = 32'h3F80_0000;
      req_x2    = 32'h4000_0000;
      req_tag   = 5'd4;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("busy_before_rst", 32'(fadd_ready), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_busy_fadd_ready", 32'(fadd_ready), 32'd0);
      check("rst_busy_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      stub_en = 1'b1;
      #1;
      check("rst_busy_release", 32'(req_ready), 32'd1);
      check("rst_busy_rsp_valid2", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      do_op(2'b00, 32'h3F80_0000, 32'h4000_0000, 5'd9, 32'h4040_0000, 1'b0, 2, 1, 32'h4000_0000, 0, 1'b0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
